// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider; runtime divisor changes land on period boundaries (phase offsets with CLK_DIV_PROG_PHASE_EN).
// Latency: en_i/load_i/sync_i take effect on the next core clock edge; outputs decode registers only.
// Backpressure: none, a load during a period is held pending (busy_o) until the wrap, last write wins.
module clk_div_prog #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
`ifdef CLK_DIV_PROG_PHASE_EN
    input  logic [NUM_CH*DIV_W-1:0] phase_i,
`endif
    input  logic [NUM_CH-1:0]       load_i,
    input  logic                    sync_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       busy_o
);

    localparam logic [DIV_W-1:0] DEF_DIV = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(2)) ? DIV_W'(2) : v;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] pend_div_q, pend_div_d;
        logic             pend_q, pend_d;
        logic             en_q;
        logic [DIV_W-1:0] req_div;
        logic             wrap;

        assign req_div = clamp_div(div_i[c*DIV_W +: DIV_W]);
        assign wrap    = en_q && (cnt_q == div_q - 1'b1);

        always_comb begin
            cnt_d      = cnt_q;
            div_d      = div_q;
            pend_div_d = pend_div_q;
            pend_d     = pend_q;
            if (sync_i) begin
                if (load_i[c]) begin
                    div_d  = req_div;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    div_d  = pend_div_q;
                    pend_d = 1'b0;
                end
`ifdef CLK_DIV_PROG_PHASE_EN
                // Offset is limited to the last count of the divisor in force after the sync.
                cnt_d = (phase_i[c*DIV_W +: DIV_W] < div_d) ? phase_i[c*DIV_W +: DIV_W]
                                                             : div_d - 1'b1;
`else
                cnt_d = '0;
`endif
            end else if (!en_q) begin
                cnt_d = '0;
                if (load_i[c]) begin
                    div_d  = req_div;
                    pend_d = 1'b0;
                end
            end else if (wrap) begin
                cnt_d = '0;
                if (load_i[c]) begin
                    div_d  = req_div;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    div_d  = pend_div_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (load_i[c]) begin
                    pend_div_d = req_div;
                    pend_d     = 1'b1;
                end
            end
            // A channel being switched off parks at zero so re-enable starts a fresh period.
            if (!en_i[c]) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q      <= '0;
                div_q      <= DEF_DIV;
                pend_div_q <= '0;
                pend_q     <= 1'b0;
                en_q       <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                div_q      <= div_d;
                pend_div_q <= pend_div_d;
                pend_q     <= pend_d;
                en_q       <= en_i[c];
            end
        end

        assign clk_o[c]  = en_q && (cnt_q < (div_q >> 1));
        assign tick_o[c] = en_q && (cnt_q == '0);
        assign busy_o[c] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: expected per-cycle {clk,tick,busy} per channel queued ahead, popped at each falling edge.
module tb_clk_div_prog;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;

    logic                    clk_i;
    logic                    rst_ni;
    logic [NUM_CH-1:0]       en_i;
    logic [NUM_CH*DIV_W-1:0] div_i;
`ifdef CLK_DIV_PROG_PHASE_EN
    logic [NUM_CH*DIV_W-1:0] phase_i;
`endif
    logic [NUM_CH-1:0]       load_i;
    logic                    sync_i;
    logic [NUM_CH-1:0]       clk_o;
    logic [NUM_CH-1:0]       tick_o;
    logic [NUM_CH-1:0]       busy_o;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp0_q[$];
    logic [2:0] exp1_q[$];

    clk_div_prog #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (en_i),
        .div_i   (div_i),
`ifdef CLK_DIV_PROG_PHASE_EN
        .phase_i (phase_i),
`endif
        .load_i  (load_i),
        .sync_i  (sync_i),
        .clk_o   (clk_o),
        .tick_o  (tick_o),
        .busy_o  (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        logic [2:0] e;
        if (exp0_q.size() > 0) begin
            e = exp0_q.pop_front();
            chk("ch0 clk_o",  32'(clk_o[0]),  32'(e[2]));
            chk("ch0 tick_o", 32'(tick_o[0]), 32'(e[1]));
            chk("ch0 busy_o", 32'(busy_o[0]), 32'(e[0]));
        end
        if (exp1_q.size() > 0) begin
            e = exp1_q.pop_front();
            chk("ch1 clk_o",  32'(clk_o[1]),  32'(e[2]));
            chk("ch1 tick_o", 32'(tick_o[1]), 32'(e[1]));
            chk("ch1 busy_o", 32'(busy_o[1]), 32'(e[0]));
        end
    end

    // Counts k in [from,to) of a period of length d; busy is high from count busy_from on.
    task automatic push_span(input int c, input int d, input int from, input int to, input int busy_from);
        logic [2:0] v;
        for (int k = from; k < to; k++) begin
            v = {(k < d / 2), (k == 0), (k >= busy_from)};
            if (c == 0) exp0_q.push_back(v);
            else        exp1_q.push_back(v);
        end
    endtask

    task automatic push_period(input int c, input int d, input int n);
        for (int i = 0; i < n; i++) push_span(c, d, 0, d, d);
    endtask

    task automatic push_idle(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            if (c == 0) exp0_q.push_back(3'b000);
            else        exp1_q.push_back(3'b000);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        en_i   = '0;
        load_i = '0;
        sync_i = 1'b0;
        div_i  = '0;
        cyc(2);
        rst_ni = 1'b1;
        cyc(1);
    endtask

    // Loads d into idle ch0 and enables it; the next falling edge still sees it idle.
    task automatic start_ch0(input int d);
        do_reset();
        div_i[15:0] = 16'(d);
        load_i      = 2'b01;
        cyc(1);
        load_i = '0;
        en_i   = 2'b01;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        en_i   = '0;
        load_i = '0;
        sync_i = 1'b0;
        div_i  = '0;
`ifdef CLK_DIV_PROG_PHASE_EN
        phase_i = {16'd3, 16'd0};
`endif
        #2;
        chk("rst clk_o",  32'(clk_o),  0);
        chk("rst tick_o", 32'(tick_o), 0);
        chk("rst busy_o", 32'(busy_o), 0);

        // Reset then enable ch0 at the default divisor of 4.
        cyc(3);
        rst_ni = 1'b1;
        en_i   = 2'b01;
        push_idle(0, 1);
        push_period(0, 4, 3);
        push_idle(1, 13);
        cyc(13);

        // Odd divisor on idle ch1.
        do_reset();
        div_i[31:16] = 16'd5;
        load_i       = 2'b10;
        cyc(1);
        load_i = '0;
        en_i   = 2'b10;
        push_idle(1, 1);
        push_period(1, 5, 2);
        push_idle(0, 11);
        cyc(11);

        // Deferred load of 3 while running at 8, requested at count 2.
        start_ch0(8);
        push_idle(0, 1);
        push_span(0, 8, 0, 8, 3);
        push_period(0, 3, 2);
        push_idle(1, 15);
        cyc(3);
        div_i[15:0] = 16'd3;
        load_i      = 2'b01;
        cyc(1);
        load_i = '0;
        cyc(11);

        // Two loads before the wrap: the later one wins.
        start_ch0(4);
        push_idle(0, 1);
        push_span(0, 4, 0, 4, 1);
        push_period(0, 10, 1);
        push_idle(1, 15);
        cyc(1);
        div_i[15:0] = 16'd6;
        load_i      = 2'b01;
        cyc(1);
        div_i[15:0] = 16'd10;
        cyc(1);
        load_i = '0;
        cyc(12);

        // Load coinciding with the wrap is used immediately, never pending.
        start_ch0(4);
        push_idle(0, 1);
        push_period(0, 4, 1);
        push_period(0, 5, 1);
        push_idle(1, 10);
        cyc(4);
        div_i[15:0] = 16'd5;
        load_i      = 2'b01;
        cyc(1);
        load_i = '0;
        cyc(5);

        // Divisor 0 behaves as 2.
        start_ch0(0);
        push_idle(0, 1);
        push_period(0, 2, 3);
        push_idle(1, 7);
        cyc(7);

        // Sync realigns channels running out of phase.
        do_reset();
        div_i  = {16'd6, 16'd4};
        load_i = 2'b11;
        cyc(1);
        load_i = '0;
        en_i   = 2'b01;
        cyc(3);
        en_i = 2'b11;
        cyc(4);
        sync_i = 1'b1;
        cyc(1);
        sync_i = 1'b0;
        push_period(0, 4, 6);
`ifdef CLK_DIV_PROG_PHASE_EN
        push_span(1, 6, 3, 6, 6);
        push_period(1, 6, 3);
        push_span(1, 6, 0, 3, 6);
`else
        push_period(1, 6, 4);
`endif
        cyc(24);

        // Async reset mid-period with a load pending.
        start_ch0(8);
        push_idle(0, 1);
        push_span(0, 8, 0, 5, 1);
        push_idle(1, 6);
        cyc(1);
        div_i[15:0] = 16'd3;
        load_i      = 2'b01;
        cyc(1);
        load_i = '0;
        cyc(4);
        chk("pre-rst busy_o", 32'(busy_o[0]), 1);
        chk("pre-rst clk_o",  32'(clk_o[0]),  0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async rst busy_o", 32'(busy_o), 0);
        chk("async rst clk_o",  32'(clk_o),  0);
        chk("async rst tick_o", 32'(tick_o), 0);
        cyc(2);
        rst_ni = 1'b1;
        en_i   = 2'b01;
        push_idle(0, 1);
        push_period(0, 4, 2);
        push_idle(1, 9);
        cyc(9);

        chk("ch0 queue drained", 32'(exp0_q.size()), 0);
        chk("ch1 queue drained", 32'(exp1_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel programmable clock divider for the calculator's synthesized top-level.
- Each channel derives a divided clock-like signal `clk_o` and a one-cycle `tick_o` strobe from one fast clock.
- Each channel's divisor is changeable at runtime and is applied only at a period boundary, so no runt pulses appear on `clk_o`.
- Consumers: display multiplexing, keypad scan, blink timers. `clk_o` drives fabric logic only; clock-tree use is not supported.

Parameters:
- NUM_CH, 2: number of independent channels.
- DIV_W, 16: divisor width per channel.
- DEFAULT_DIV, 4: divisor loaded into every channel at reset; values <2 are clamped to 2.

Ports:
- clk_i  in  1  fast clock.
- rst_ni  in  1  asynchronous, active-low reset.
- en_i  in  NUM_CH  per-channel run enable.
- div_i  in  NUM_CH*DIV_W  requested divisor; channel c occupies bits [c*DIV_W +: DIV_W].
- load_i  in  NUM_CH  one-cycle request to adopt div_i for that channel.
- sync_i  in  1  restart all channels phase-aligned.
- clk_o  out  NUM_CH  divided clock.
- tick_o  out  NUM_CH  one-cycle strobe at period start.
- busy_o  out  NUM_CH  a divisor load is pending.

Behaviour:
- Per-channel state:
  - `cnt_q` [DIV_W]: period counter.
  - `div_q` [DIV_W]: active divisor.
  - `pend_div_q` [DIV_W]: pending divisor.
  - `pend_q`: pending flag.
  - `en_q`: registered enable.
- Reset (async, rst_ni=0):
  - cnt_q=0, div_q=max(DEFAULT_DIV,2), pend_q=0, en_q=0.
  - Outputs: clk_o=0, tick_o=0, busy_o=0.
- Clamping: every divisor value (div_i, DEFAULT_DIV) is clamped to ≥2 before storage. 0 and 1 behave as 2.
- Enable:
  - en_q <= en_i each cycle, so a change in en_i takes effect 1 cycle later.
  - While en_q=0: cnt_q held at 0, clk_o=0, tick_o=0.
  - On the first enabled cycle cnt_q=0, so tick_o=1 and clk_o=1.
- Counting: when en_q=1, cnt_q increments and wraps to 0 at div_q-1 (this is the "wrap" event).
- Outputs (decoded from registers, glitch-free, no combinational path from inputs):
  - clk_o = en_q && (cnt_q < div_q>>1). High for floor(div/2) cycles, low for the rest of the period.
  - tick_o = en_q && (cnt_q==0).
  - busy_o = pend_q.
- Load handling, in priority order:
  1. sync_i=1: every channel sets cnt_q<=0. If pend_q, then div_q<=pend_div_q and pend_q<=0. A load_i asserted in the same cycle is applied directly to div_q.
  2. load_i=1 coinciding with a wrap, or with en_q=0: div_q<=clamp(div_i) directly; pend_q stays 0.
  3. load_i=1 otherwise: pend_div_q<=clamp(div_i), pend_q<=1. A second load before the wrap overwrites pend_div_q (last write wins).
  4. Wrap with pend_q=1: div_q<=pend_div_q, pend_q<=0, cnt_q<=0.
- Channels are fully independent except for the shared sync_i.
- Reset mid-period: all state returns to reset values immediately; pending loads are discarded.
- Counter width is DIV_W bits; no overflow is possible because cnt_q < div_q ≤ 2^DIV_W-1.

Optional Feature:
- Macro: CLK_DIV_PROG_PHASE_EN.
- With the macro defined:
  - Extra input phase_i, NUM_CH*DIV_W bits.
  - On sync_i, each channel loads cnt_q<=min(phase_i[c], div_q_next-1), where div_q_next is the divisor in effect after that sync.
  - This provides programmable phase offsets between channels.
- Without the macro: port phase_i is absent and sync_i loads cnt_q<=0.

Test Plan:
- Reset then enable: rst_ni low 3 cycles, release, NUM_CH=2, en_i=2'b01, DEFAULT_DIV=4 -> ch0 clk_o pattern 1,1,0,0 repeating, tick_o every 4th cycle starting 1 cycle after en_i; ch1 clk_o and tick_o stay 0.
- Odd divisor: load div=5 on an idle channel, enable -> clk_o high 2 cycles, low 3; tick_o period 5.
- Deferred load: running div=8, load_i with div_i=3 at cnt_q=2 -> busy_o=1 until the wrap, one full 8-cycle period completes, then a 3-cycle period starts (clk_o 1,0,0); busy_o=0 after the wrap.
- Load collision and overwrite: load 6 then load 10 before the wrap -> the next period is 10. Load coinciding with a wrap -> the new value is used in the immediately following period and busy_o never asserts. Load of div_i=0 -> behaves as div=2.
- Sync alignment: ch0 div=4 and ch1 div=6 running out of phase, pulse sync_i -> both tick_o=1 on the same cycle after sync, and again coincide every 12 cycles. With CLK_DIV_PROG_PHASE_EN and phase_i ch1=3 -> ch1 tick_o lags ch0 tick_o by 3 cycles.
- Async reset mid-period: assert rst_ni while cnt_q=5 with a load pending -> clk_o, tick_o and busy_o drop in the same cycle without waiting for a clock edge; after release, divisor=DEFAULT_DIV.
